data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised single-port data memory with a valid/ready request channel, registered read response, out-of-range detection and a hardware clear sweep after reset. Sits between the processor's load/store stage and the data store, replacing the fixed 64×16 memory. A single-entry response register provides backpressure so the datapath can stall without losing read data.

## Interface
- DATA_W, 16, word width in bits (multiple of 8 when byte writes are compiled in)
- ADDR_W, 8, request address width
- DEPTH, 64, number of words implemented; 1 ≤ DEPTH ≤ 2^ADDR_W
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte-lane write enables (present only with DMEM_BYTE_WRITE_EN)
- rsp_valid  out  1  response held in the output register
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for write responses and errors
- rsp_err  out  1  accepted address was ≥ DEPTH
- busy  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR, RUN.
- reset: state ← CLEAR, clear pointer ← 0, rsp_valid ← 0, rsp_rdata ← 0, rsp_err ← 0. During reset assertion req_ready = 0 and busy = 1.
- CLEAR: each cycle writes 0 to mem[ptr], ptr increments. After the write to ptr = DEPTH−1, go to RUN. busy = 1 and req_ready = 0 throughout. The sweep takes exactly DEPTH cycles.
- RUN: busy = 0; req_ready = !rsp_valid || rsp_ready.
- Accepted read, addr < DEPTH: rsp_rdata ← mem[addr], rsp_err ← 0.
- Accepted write, addr < DEPTH: mem[addr] ← wdata; response with rsp_rdata = 0, rsp_err = 0.
- Accepted request with addr ≥ DEPTH: memory is untouched; response with rsp_rdata = 0, rsp_err = 1.
- Every accepted request produces exactly one response, in order.
- Response register: loaded on accept; holds its value while rsp_valid && !rsp_ready. It clears to rsp_valid = 0 when taken and no new request is accepted. Take and accept in the same cycle replaces the response with no bubble.
- Write followed by a read of the same address on the next accepted cycle returns the new data. Memory is never read combinationally.
- Reset asserted mid-sweep or mid-transfer restarts the sweep from 0. Any pending response is discarded.

## Timing
- Read latency: 1 cycle. Data accepted at edge N is visible on rsp_rdata after edge N.
- Sustained throughput is 1 request/cycle while rsp_ready = 1.
- First possible accept is DEPTH cycles after reset deasserts.
- Outputs are driven from registers, except req_ready, which is combinational from rsp_valid, rsp_ready and state.

## Configuration
- DMEM_BYTE_WRITE_EN defined: the req_be port exists. A write updates only the lanes whose be bit is 1. A write with be = 0 still produces a normal response. DATA_W must be a multiple of 8, checked by an elaboration-time error.
- Not defined: no req_be port; every write updates the full word.

## Structure
- Shared package dmem_pkg holds the state enum (CLEAR, RUN), default width/depth constants, and a response struct {rdata, err}.
- One sub-module, dmem_array: a plain synchronous-write, registered-read RAM with optional lane mask, so it can be replaced by a vendor macro. data_mem_ctrl owns the FSM, clear pointer, range check and response register.

## Test plan
- Reset, then count cycles: busy = 1 for exactly 64 cycles (DEPTH = 64), req_ready = 0 meanwhile; afterwards, reads of addresses 0, 1 and 63 return 0x0000.
- Write 0x1234 to addr 2, then immediately read addr 2 → response 0x1234 one cycle after the read is accepted, rsp_err = 0.
- Read addr 64 with DEPTH = 64 → rsp_err = 1, rsp_rdata = 0; a write to addr 70 leaves all memory contents unchanged.
- Hold rsp_ready = 0 with a read of addr 2 pending → req_ready = 0, and rsp_rdata stays 0x1234 for 5 cycles. Then issue back-to-back reads of addr 1 and addr 2 with rsp_ready = 1 → responses on consecutive cycles, no bubble.
- With DMEM_BYTE_WRITE_EN: write 0xFFFF to addr 3, then write 0xAB00 with be = 2'b10 → read returns 0xABFF.
- Assert reset for 1 cycle at sweep cycle 30 and again while rsp_valid = 1 → sweep restarts (busy for 64 more cycles), and rsp_valid = 0 after the reset edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory controller.
// Consumers: data_mem_ctrl, dmem_array users and their benches.
package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DEPTH  = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmemState_t;

    // Response as seen by the load/store stage at the default word width.
    typedef struct packed {
        logic [DMEM_DATA_W-1:0] rdata;
        logic                   err;
    } dmemRsp_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM: synchronous write with per-lane mask, registered read.
// Kept free of control logic so a vendor macro can be dropped in instead.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LANES-1:0]  mask,
    output logic [DATA_W-1:0] rdata
);

    localparam int LANE_W = DATA_W / LANES;

    // One narrow array per lane keeps each lane a single-writer block RAM.
    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
        logic [LANE_W-1:0] laneMem [DEPTH];
        logic [LANE_W-1:0] laneRdata;

        always_ff @(posedge clk) begin
            if (we && mask[gi]) begin
                laneMem[addr] <= wdata[gi*LANE_W +: LANE_W];
            end
            if (re) begin
                laneRdata <= laneMem[addr];
            end
        end

        assign rdata[gi*LANE_W +: LANE_W] = laneRdata;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: clear sweep after reset, range check, 1-entry response register.
// Optional byte-lane writes via the DMEM_BYTE_WRITE_EN macro (adds req_be).
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_BYTE_WRITE_EN
    localparam int LANES = DATA_W / 8;
    if ((DATA_W % 8) != 0) begin : gWidthCheck
        $error("data_mem_ctrl: DATA_W must be a multiple of 8 for byte-lane writes");
    end
`else
    localparam int LANES = 1;
`endif
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    dmemState_t        stateReg, stateNext;
    logic [ADDR_W-1:0] ptrReg, ptrNext;
    logic              rspValidReg;
    logic              rspZeroReg;
    logic              rspErrReg;
    logic              inRange;
    logic              accept;

    logic              ramWe;
    logic              ramRe;
    logic [RAM_AW-1:0] ramAddr;
    logic [DATA_W-1:0] ramWdata;
    logic [LANES-1:0]  ramMask;
    logic [DATA_W-1:0] ramRdata;

    assign inRange   = ({1'b0, req_addr} < DEPTH_L);
    assign req_ready = !reset && (stateReg == RUN) && (!rspValidReg || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign busy      = reset || (stateReg == CLEAR);

    always_comb begin
        stateNext = stateReg;
        ptrNext   = ptrReg;
        if (stateReg == CLEAR) begin
            ptrNext = ptrReg + ADDR_W'(1);
            if (ptrReg == LAST_PTR) begin
                stateNext = RUN;
                ptrNext   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= CLEAR;
            ptrReg      <= '0;
            rspValidReg <= 1'b0;
            rspZeroReg  <= 1'b1;
            rspErrReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            ptrReg   <= ptrNext;
            if (accept) begin
                rspValidReg <= 1'b1;
                rspZeroReg  <= req_we || !inRange;
                rspErrReg   <= !inRange;
            end else if (rsp_ready) begin
                rspValidReg <= 1'b0;
                rspZeroReg  <= 1'b1;
                rspErrReg   <= 1'b0;
            end
        end
    end

    // The sweep owns the RAM port; out-of-range requests never reach it.
    always_comb begin
        ramWe    = accept && req_we && inRange;
        ramRe    = accept && !req_we && inRange;
        ramAddr  = req_addr[RAM_AW-1:0];
        ramWdata = req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
        ramMask  = req_be;
`else
        ramMask  = '1;
`endif
        if (stateReg == CLEAR) begin
            ramWe    = 1'b1;
            ramRe    = 1'b0;
            ramAddr  = ptrReg[RAM_AW-1:0];
            ramWdata = '0;
            ramMask  = '1;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW),
        .LANES  (LANES)
    ) uArray (
        .clk   (clk),
        .we    (ramWe),
        .re    (ramRe),
        .addr  (ramAddr),
        .wdata (ramWdata),
        .mask  (ramMask),
        .rdata (ramRdata)
    );

    // RAM output only advances on accepted reads, so it holds through a stall.
    assign rsp_valid = rspValidReg;
    assign rsp_err   = rspErrReg;
    assign rsp_rdata = rspZeroReg ? '0 : ramRdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl at default parameters (DEPTH = 64, DATA_W = 16).
// Byte-lane steps run only when DMEM_BYTE_WRITE_EN is defined.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
`ifdef DMEM_BYTE_WRITE_EN
    logic [1:0]  req_be = 2'b11;
`endif
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .req_be    (req_be),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkRsp(input string tag, input dmemRsp_t exp);
        chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rdata"}, 32'(rsp_rdata), 32'(exp.rdata));
        chk({tag, " err"},   32'(rsp_err),   32'(exp.err));
        $display("txn %s: rdata=0x%04h err=%0d", tag, rsp_rdata, rsp_err);
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                         input string tag, input dmemRsp_t exp);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        #1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chkRsp(tag, exp);
    endtask

    task automatic countSweep(input string tag);
        int n;
        logic bad;
        n = 0;
        bad = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            if (req_ready !== 1'b0) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, 32'(n), 32'd64);
        chk({tag, " ready low"}, 32'(bad), 32'd0);
        $display("txn %s: busy for %0d cycles", tag, n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy",      32'(busy),      32'd1);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset rsp_err",   32'(rsp_err),   32'd0);
        reset = 1'b0;
        #1;
        countSweep("sweep0");

        issue(1'b0, 8'd0,  16'h0, "rd0 cleared",  '{rdata: 16'h0000, err: 1'b0});
        issue(1'b0, 8'd1,  16'h0, "rd1 cleared",  '{rdata: 16'h0000, err: 1'b0});
        issue(1'b0, 8'd63, 16'h0, "rd63 cleared", '{rdata: 16'h0000, err: 1'b0});

        issue(1'b1, 8'd2,  16'h1234, "wr2",       '{rdata: 16'h0000, err: 1'b0});
        issue(1'b0, 8'd2,  16'h0,    "rd2 after wr", '{rdata: 16'h1234, err: 1'b0});
        issue(1'b1, 8'd1,  16'h00A5, "wr1",       '{rdata: 16'h0000, err: 1'b0});

        issue(1'b0, 8'd64, 16'h0,    "rd64 oor",  '{rdata: 16'h0000, err: 1'b1});
        issue(1'b1, 8'd70, 16'hDEAD, "wr70 oor",  '{rdata: 16'h0000, err: 1'b1});
        issue(1'b0, 8'd6,  16'h0,    "rd6 alias untouched", '{rdata: 16'h0000, err: 1'b0});
        issue(1'b0, 8'd2,  16'h0,    "rd2 untouched", '{rdata: 16'h1234, err: 1'b0});

        // Pending response is the read of addr 2; stall it for 5 cycles.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall req_ready", 32'(req_ready), 32'd0);
            chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall rsp_rdata", 32'(rsp_rdata), 32'h1234);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chkRsp("b2b rd1", '{rdata: 16'h00A5, err: 1'b0});
        req_addr = 8'd2;
        @(negedge clk);
        chkRsp("b2b rd2", '{rdata: 16'h1234, err: 1'b0});
        req_valid = 1'b0;
        @(negedge clk);
        chk("drain rsp_valid", 32'(rsp_valid), 32'd0);

`ifdef DMEM_BYTE_WRITE_EN
        req_be = 2'b11;
        issue(1'b1, 8'd3, 16'hFFFF, "wr3 full",  '{rdata: 16'h0000, err: 1'b0});
        req_be = 2'b10;
        issue(1'b1, 8'd3, 16'hAB00, "wr3 hi",    '{rdata: 16'h0000, err: 1'b0});
        req_be = 2'b00;
        issue(1'b1, 8'd3, 16'h0000, "wr3 none",  '{rdata: 16'h0000, err: 1'b0});
        req_be = 2'b11;
        issue(1'b0, 8'd3, 16'h0,    "rd3 lanes", '{rdata: 16'hABFF, err: 1'b0});
`endif

        // Reset 30 cycles into a sweep restarts it from the beginning.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid sweep busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid sweep rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        countSweep("sweep restart");

        // Reset with a response pending discards it and clears memory again.
        issue(1'b1, 8'd2, 16'h5555, "wr2 pre", '{rdata: 16'h0000, err: 1'b0});
        issue(1'b0, 8'd2, 16'h0,    "rd2 pre", '{rdata: 16'h5555, err: 1'b0});
        rsp_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("xfer reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("xfer reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("xfer reset busy",      32'(busy),      32'd1);
        chk("xfer reset req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        countSweep("sweep after xfer");
        issue(1'b0, 8'd2, 16'h0, "rd2 recleared", '{rdata: 16'h0000, err: 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
